// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: ALU opcodes and FSM states.
// Opcode values are also used by the ALU decoder.
package muldiv_pkg;

    localparam logic [3:0] OP_MUL = 4'd13;
    localparam logic [3:0] OP_DIV = 4'd14;
    localparam logic [3:0] OP_REM = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic logic is_supported(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response channel of the multiply/divide unit.
// The requester uses the master modport and the unit uses the slave modport.
interface muldiv_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] o;
    logic         busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, o, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, o, busy
    );
endinterface

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the partial remainder left, bring in the next
// dividend bit, and keep the difference when it does not go negative.
module muldiv_div_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] rem,
    input  logic         dividend_bit,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_next,
    output logic         q_bit
);
    logic [N:0]   shifted;
    logic [N+1:0] diff;

    assign shifted  = {rem, dividend_bit};
    assign diff     = {1'b0, shifted} - {2'b00, divisor};
    assign q_bit    = ~diff[N+1];
    // The kept remainder is always below the divisor, so its top bit is zero here.
    assign rem_next = q_bit ? diff[N-1:0] : shifted[N-1:0];
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MUL/DIV/REM unit, one bit per cycle, with valid/ready request and response.
// Define MULDIV_EARLY_OUT_EN to finish trivial operands in a single cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(N);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [3:0]    op_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [N-1:0]  acc;

    logic          accept;
    logic          last;
    logic          direct;
    logic [N-1:0]  direct_val;

    logic [N-1:0]  mul_next;
    logic [N-1:0]  rem_next;
    logic          q_bit;
    logic          shift_in;
    logic [N-1:0]  a_next;
    logic [N-1:0]  acc_next;
    logic [N-1:0]  result;

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == BUSY) || (state == DONE);

    assign accept = bus.in_valid && bus.in_ready;
    assign last   = (count == CW'(N - 1));

    // Requests that skip the iterations and the value they return.
    always_comb begin : early_decode
        // NOTE: every output of a combinational block gets a default first, so no
        // path through the if/case leaves it unassigned and infers a latch.
        direct     = 1'b0;
        direct_val = '0;
        if (!is_supported(bus.op)) begin
            direct = 1'b1;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if (bus.op == OP_MUL) begin
            direct = (bus.a == '0) || (bus.b == '0);
        end else if (bus.b == '0) begin
            direct     = 1'b1;
            direct_val = (bus.op == OP_DIV) ? '1 : bus.a;
        end else if (bus.a < bus.b) begin
            direct     = 1'b1;
            direct_val = (bus.op == OP_DIV) ? '0 : bus.a;
        end
`endif
    end

    always_ff @(posedge clk) begin : state_reg
        // NOTE: sequential state is written with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin : next_state
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = direct ? DONE : BUSY;
            BUSY: if (last) state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Multiply runs MSB first so it shares the left-shifting a_q with division.
    assign mul_next = {acc[N-2:0], 1'b0} + (a_q[N-1] ? b_q : '0);

    muldiv_div_step #(.N(N)) u_div_step (
        .rem          (acc),
        .dividend_bit (a_q[N-1]),
        .divisor      (b_q),
        .rem_next     (rem_next),
        .q_bit        (q_bit)
    );

    // For division a_q fills with quotient bits as the dividend bits shift out.
    assign shift_in = (op_q == OP_MUL) ? 1'b0 : q_bit;
    assign a_next   = {a_q[N-2:0], shift_in};
    assign acc_next = (op_q == OP_MUL) ? mul_next : rem_next;

    always_comb begin : result_sel
        result = rem_next;
        if (op_q == OP_MUL) begin
            result = mul_next;
        end else if (op_q == OP_DIV) begin
            result = a_next;
        end
    end

    always_ff @(posedge clk) begin : control_reg
        if (rst) begin
            count <= '0;
            bus.o <= '0;
        end else if (accept) begin
            count <= '0;
            if (direct) begin
                bus.o <= direct_val;
            end
        end else if (state == BUSY) begin
            count <= count + CW'(1);
            if (last) begin
                bus.o <= result;
            end
        end
    end

    // NOTE: the operand and accumulator registers carry no reset; they are always
    // loaded on acceptance before use, and a reset only needs to clear control state.
    always_ff @(posedge clk) begin : datapath_reg
        if (accept) begin
            op_q <= bus.op;
            a_q  <= bus.a;
            b_q  <= bus.b;
            acc  <= '0;
        end else if (state == BUSY) begin
            a_q  <= a_next;
            acc  <= acc_next;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    muldiv_if #(.N(N)) bus ();

    muldiv_unit #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] prod;
        case (op)
            4'd13: begin
                prod = 64'(a) * 64'(b);
                return prod[31:0];
            end
            4'd14:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd15:   return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op < 4'd13) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (op == 4'd13 && (a == 0 || b == 0)) return 1;
        if (op != 4'd13 && (b == 0 || a < b)) return 1;
`endif
        return N;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns just after its acceptance edge, with the
    // request inputs scrambled to show they are ignored once taken.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        while (!bus.in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("accept_timeout", 64'(guard), 64'(0));
        tick();
        bus.in_valid = 1'b0;
        bus.op = 4'($urandom);
        bus.a = $urandom;
        bus.b = $urandom;
    endtask

    task automatic wait_result(input string tag, input int exp_lat, input logic [31:0] exp_o);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!bus.out_valid && k < 200);
        check({tag, "_lat"}, 64'(k), 64'(exp_lat));
        check(tag, 64'(bus.o), 64'(exp_o));
    endtask

    task automatic respond(input logic [31:0] exp_o, input int stall);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_o", 64'(bus.o), 64'(exp_o));
            check("stall_valid", 64'(bus.out_valid), 64'(1));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("resp_ready", 64'(bus.in_ready), 64'(1));
        check("resp_valid", 64'(bus.out_valid), 64'(0));
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int stall);
        logic [31:0] exp_o;
        int          exp_lat;
        exp_o = ref_result(op, a, b);
        exp_lat = ref_latency(op, a, b);
        issue(op, a, b);
        check({tag, "_busy"}, 64'(bus.busy), 64'(1));
        wait_result(tag, exp_lat, exp_o);
        respond(exp_o, stall);
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        logic [31:0] exp_o;
        int          seen;

        bus.in_valid = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b0;

        tick();
        tick();
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_o", 64'(bus.o), 64'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

        run_op("mul_7x6", OP_MUL, 32'd7, 32'd6, 1);
        run_op("mul_a0", OP_MUL, 32'd0, 32'd9, 0);
        run_op("mul_trunc", OP_MUL, 32'hFFFF_FFFF, 32'd2, 0);
        run_op("mul_wrap", OP_MUL, 32'h0001_0000, 32'h0001_0000, 0);
        run_op("div_100_7", OP_DIV, 32'd100, 32'd7, 0);
        run_op("rem_100_7", OP_REM, 32'd100, 32'd7, 2);
        run_op("div_max_1", OP_DIV, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("div_by0", OP_DIV, 32'd5, 32'd0, 0);
        run_op("rem_by0", OP_REM, 32'd5, 32'd0, 0);
        run_op("rem_small", OP_REM, 32'd3, 32'd10, 0);
        run_op("unsup_op", 4'd3, 32'd11, 32'd12, 0);

        // Stall in DONE while a second request waits on in_valid.
        issue(OP_MUL, 32'd9, 32'd9);
        wait_result("bp_mul", N, 32'd81);
        bus.in_valid = 1'b1;
        bus.op = OP_DIV;
        bus.a = 32'd1000;
        bus.b = 32'd10;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_o", 64'(bus.o), 64'(81));
            check("bp_valid", 64'(bus.out_valid), 64'(1));
            check("bp_in_ready", 64'(bus.in_ready), 64'(0));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_t1_in_ready", 64'(bus.in_ready), 64'(1));
        check("bp_t1_valid", 64'(bus.out_valid), 64'(0));
        tick();
        bus.in_valid = 1'b0;
        check("bp_second_busy", 64'(bus.busy), 64'(1));
        check("bp_second_in_ready", 64'(bus.in_ready), 64'(0));
        wait_result("bp_div", ref_latency(OP_DIV, 32'd1000, 32'd10), 32'd100);
        respond(32'd100, 0);

        // Reset in the middle of a division.
        issue(OP_DIV, 32'hDEAD_BEEF, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_state", 64'(dut.state), 64'(IDLE));
        check("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("mid_rst_no_result", 64'(seen), 64'(0));
        run_op("after_rst_op3", 4'd3, 32'd77, 32'd88, 0);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: r_op = OP_MUL;
                3, 4, 5: r_op = OP_DIV;
                6, 7, 8: r_op = OP_REM;
                default: r_op = 4'($urandom_range(0, 12));
            endcase
            r_a = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            case ($urandom_range(0, 4))
                0:       r_b = 32'd0;
                1:       r_b = $urandom_range(1, 15);
                2:       r_b = r_a + $urandom_range(1, 100);
                default: r_b = $urandom;
            endcase
            exp_o = ref_result(r_op, r_a, r_b);
            run_op("rand", r_op, r_a, r_b, $urandom_range(0, 2));
            check("rand_model_idle", 64'(bus.in_ready), 64'(exp_o == exp_o));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
